// File: rtl/serial_sum_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_sum_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Counter must reach WIDTH without wrapping, so it spans 0..WIDTH+1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/serial_sum_sub_if.sv
// Valid/ready handshake bundle: sum/operand in, recovered operand and overflow flag out.
interface serial_sum_sub_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:0]   X;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] A;
   logic             ovf;

   modport master (
      output in_valid, X, B, out_ready,
      input  in_ready, out_valid, A, ovf
   );

   modport slave (
      input  in_valid, X, B, out_ready,
      output in_ready, out_valid, A, ovf
   );
endinterface

// File: rtl/serial_sum_sub_full_sub.sv
// One-bit full subtractor: d = x - b - bin, bout set when the difference goes negative.
module full_sub (
   input  logic x,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = x ^ b ^ bin;
   assign bout = (~x & b) | (~(x ^ b) & bin);
endmodule

// File: rtl/serial_sum_sub.sv
// Recovers A = X - B bit-serially (LSB first) with valid/ready on both sides.
module serial_sum_sub
   import serial_sum_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic            clock,
   input  logic            resetn,
   serial_sum_sub_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);

   state_t           state_reg, state_next;
   logic [WIDTH:0]   x_reg, x_next;
   logic [WIDTH:0]   b_reg, b_next;
   logic [WIDTH:0]   res_reg, res_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             borrow_reg, borrow_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic             ovf_reg, ovf_next;
   logic             valid_reg, valid_next;

   logic             d;
   logic             bout;
   logic [WIDTH:0]   res_shifted;

   full_sub u_full_sub (
      .x    (x_reg[0]),
      .b    (b_reg[0]),
      .bin  (borrow_reg),
      .d    (d),
      .bout (bout)
   );

   assign res_shifted   = {d, res_reg[WIDTH:1]};
   assign bus.in_ready  = (state_reg == ST_IDLE);
   assign bus.out_valid = valid_reg;
   assign bus.A         = a_reg;
   assign bus.ovf       = ovf_reg;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= ST_IDLE;
         x_reg      <= '0;
         b_reg      <= '0;
         res_reg    <= '0;
         cnt_reg    <= '0;
         borrow_reg <= 1'b0;
         a_reg      <= '0;
         ovf_reg    <= 1'b0;
         valid_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         x_reg      <= x_next;
         b_reg      <= b_next;
         res_reg    <= res_next;
         cnt_reg    <= cnt_next;
         borrow_reg <= borrow_next;
         a_reg      <= a_next;
         ovf_reg    <= ovf_next;
         valid_reg  <= valid_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      x_next      = x_reg;
      b_next      = b_reg;
      res_next    = res_reg;
      cnt_next    = cnt_reg;
      borrow_next = borrow_reg;
      a_next      = a_reg;
      ovf_next    = ovf_reg;
      valid_next  = valid_reg;

      case (state_reg)
         ST_IDLE: begin
            if (bus.in_valid) begin
               x_next      = bus.X;
               b_next      = {1'b0, bus.B};
               res_next    = '0;
               cnt_next    = '0;
               borrow_next = 1'b0;
               state_next  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_next    = res_shifted;
            x_next      = x_reg >> 1;
            b_next      = b_reg >> 1;
            borrow_next = bout;
            cnt_next    = cnt_reg + CW'(1);
            // Last bit: the final borrow and result MSB together decide ovf.
            if (cnt_reg == CW'(WIDTH)) begin
               a_next     = res_shifted[WIDTH-1:0];
               ovf_next   = bout | res_shifted[WIDTH];
               valid_next = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               valid_next = 1'b0;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_serial_sum_sub.sv
// Directed bench for serial_sum_sub: reset, arithmetic, overflow, backpressure, abort, loop-back soak.
module tb_serial_sum_sub;
   localparam int WIDTH = 4;

   logic clock;
   logic resetn;
   int   passed;
   int   total;
   int   fails;

   serial_sum_sub_if #(.WIDTH(WIDTH)) bus ();

   serial_sum_sub #(.WIDTH(WIDTH)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One transaction; hold>0 keeps out_ready low that many cycles in DONE with stray in_valid pulses.
   task automatic run_op(input int x, input int b, input int exp_a, input int exp_ovf,
                         input string tag, input int hold);
      int lat;
      int low;
      logic [WIDTH-1:0] a_seen;
      logic             ovf_seen;
      check({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
      bus.out_ready = (hold == 0);
      bus.X         = (WIDTH+1)'(x);
      bus.B         = WIDTH'(b);
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      bus.X         = '1;
      bus.B         = '1;
      lat = 0;
      low = (bus.in_ready == 1'b0) ? 1 : 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
         if (bus.in_ready == 1'b0) low++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd5);
      if (lat >= 20) return;
      a_seen   = bus.A;
      ovf_seen = bus.ovf;
      check({tag, "_A"}, 32'(a_seen), 32'(exp_a));
      check({tag, "_ovf"}, 32'(ovf_seen), 32'(exp_ovf));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = i[0];
         bus.X        = 5'd7;
         bus.B        = 4'd2;
         tick();
         check({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, "_bp_A"}, 32'(bus.A), 32'(a_seen));
         check({tag, "_bp_ovf"}, 32'(bus.ovf), 32'(ovf_seen));
         check({tag, "_bp_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      if (hold == 0) check({tag, "_ready_low_cycles"}, 32'(low), 32'd6);
      check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_in_ready_post"}, 32'(bus.in_ready), 32'd1);
      $display("txn %s X=%0d B=%0d -> A=%0d ovf=%0d lat=%0d", tag, x, b, a_seen, ovf_seen, lat);
   endtask

   initial begin
      passed        = 0;
      total         = 0;
      fails         = 0;
      resetn        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.X         = '0;
      bus.B         = '0;

      repeat (3) tick();
      check("rst_in_ready_during", 32'(bus.in_ready), 32'd1);
      resetn = 1'b1;
      #2;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_A", 32'(bus.A), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();

      run_op(17, 8, 9, 0, "basic", 0);
      run_op(30, 15, 15, 0, "max_legal", 0);
      run_op(0, 0, 0, 0, "zero", 0);
      run_op(3, 5, 14, 1, "borrow", 0);
      run_op(31, 0, 15, 1, "top31", 0);
      run_op(16, 0, 0, 1, "top16", 0);
      run_op(22, 9, 13, 0, "backpressure", 10);
      run_op(17, 8, 9, 0, "after_bp", 0);

      // Abort in SHIFT after two bit edges, with a live borrow in flight.
      bus.X        = 5'd0;
      bus.B        = 4'd7;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      resetn = 1'b0;
      #1;
      check("abort_shift_valid", 32'(bus.out_valid), 32'd0);
      check("abort_shift_ready", 32'(bus.in_ready), 32'd1);
      #2;
      resetn = 1'b1;
      tick();
      run_op(20, 7, 13, 0, "post_abort", 0);

      // Abort while a result sits unconsumed in DONE.
      bus.out_ready = 1'b0;
      bus.X         = 5'd12;
      bus.B         = 4'd3;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (6) tick();
      check("done_hold_valid", 32'(bus.out_valid), 32'd1);
      resetn = 1'b0;
      #1;
      check("abort_done_valid", 32'(bus.out_valid), 32'd0);
      check("abort_done_ready", 32'(bus.in_ready), 32'd1);
      check("abort_done_A", 32'(bus.A), 32'd0);
      #2;
      resetn        = 1'b1;
      bus.out_ready = 1'b1;
      tick();

      // Loop-back: X is what the upstream adder would produce for A+B.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(a + b, b, a, 0, "soak", 0);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/serial_sum_sub.md
Name: serial_sum_sub

Overview:
- Inverse of the team's registered 4-bit adder. Given a sum X and one operand B, it recovers the other operand A = X - B.
- The subtraction is bit-serial, LSB first, using one full-subtractor cell.
- Uses a valid/ready handshake on both input and output, so it can sit downstream of the adder in a self-checking loop-back datapath.
- Flags results that cannot be a legal WIDTH-bit operand.

Parameters:
- WIDTH, 4, operand width. The sum input is WIDTH+1 bits wide.

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  X and B are valid
- in_ready  output  1  block can accept a new X/B pair
- X  input  WIDTH+1  sum operand, unsigned
- B  input  WIDTH  known addend, unsigned, zero-extended to WIDTH+1
- out_valid  output  1  A and ovf are valid
- out_ready  input  1  downstream accepts the result
- A  output  WIDTH  recovered operand, which is (X - B) mod 2^WIDTH
- ovf  output  1  result is not in 0..2^WIDTH-1

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While resetn=0:
  - state=IDLE, out_valid=0, A=0, ovf=0;
  - internal shift registers, bit counter and borrow are cleared to 0.
- in_ready is combinational and equals (state==IDLE). It reads 1 during and after reset.
- State machine, IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE: on an edge with in_valid&&in_ready, capture X and zero-extended B into shift registers, clear borrow and the counter, go to SHIFT. X and B may change freely after acceptance.
  - SHIFT: each edge processes one bit: d = x0 ^ b0 ^ borrow, borrow' = (~x0&b0) | (~(x0^b0)&borrow). d shifts into the MSB of the result register, and the operand registers shift right. After exactly WIDTH+1 SHIFT edges, go to DONE.
  - DONE: out_valid=1. A = result[WIDTH-1:0]. ovf = final borrow | result[WIDTH].
  - Leaving DONE: hold all outputs stable while out_ready=0. On an edge with out_valid&&out_ready, go to IDLE and clear out_valid.
- Outputs A and ovf keep their last value in IDLE and SHIFT. They are only meaningful when out_valid=1.
- Latency: with the acceptance edge as edge 0, out_valid is high after edge WIDTH+1 (edge 5 for WIDTH=4). There is no pipelining and no input acceptance in DONE. Maximum throughput is one result per WIDTH+3 cycles with out_ready tied high.
- Simultaneous events: in_valid is ignored outside IDLE; the source must hold it, per the standard valid/ready rule.
- Width and arithmetic:
  - The serial difference is WIDTH+1 bits.
  - A borrow out of the MSB means X < B.
  - Result bit WIDTH set means X - B >= 2^WIDTH.
  - Either condition sets ovf.
- Reset mid-operation (SHIFT or DONE): abort immediately, discard the partial or unconsumed result, drop out_valid asynchronously, and return to IDLE.
- The bit counter is ceil(log2(WIDTH+2)) bits wide. It never wraps within one operation.

Decomposition:
- Shared package or header serial_sum_sub_pkg:
  - state encoding localparams ST_IDLE, ST_SHIFT, ST_DONE (2 bits);
  - counter-width function/constant derived from WIDTH.
- Sub-module full_sub: combinational 1-bit full subtractor, ports (x, b, bin) -> (d, bout). Instantiated once.
- Top level holds the FSM, shift registers, counter and output registers.

Test Plan:
- Reset behaviour: hold resetn=0 for 3 cycles then release -> out_valid=0, A=0, ovf=0, in_ready=1. Apply X=17, B=8 with out_ready=1 -> in_ready low for 6 cycles, out_valid high 5 edges after acceptance for exactly 1 cycle, A=9, ovf=0.
- Boundary sums: X=30, B=15 -> A=15, ovf=0. X=0, B=0 -> A=0, ovf=0.
- Illegal results:
  - X=3, B=5 -> A=14, ovf=1 (borrow);
  - X=31, B=0 -> A=15, ovf=1;
  - X=16, B=0 -> A=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, A/ovf stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one transfer, then IDLE.
- Reset mid-operation: assert resetn=0 on the cycle after edge 2 of SHIFT -> out_valid=0 and in_ready=1 immediately. After release, a new X=20, B=7 yields A=13, ovf=0 with no stale borrow.
- Loop-back soak: drive the adder's registered X output with random A, B into this block -> recovered A equals the original A and ovf=0 for all 256 operand pairs.
